uart_frame_parser: RTL and testbench

- Consumes the byte stream from the UART receiver: `data[7:0]` plus the one-cycle `update` strobe per received byte.
- Assembles bytes into framed commands: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Verifies the frame and presents CMD, LEN and the buffered payload to the command logic downstream.
- Holds each good frame until the consumer acknowledges it.

---
 rtl/uart_frame_parser.sv | 126 ++++++++++++
 tb/tb_uart_frame_parser.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser for the UART byte stream: SYNC, CMD, LEN, payload, CHK.
// A good frame is held, with its payload buffered, until the consumer acks it.
module uart_frame_parser #(
  parameter logic [7:0] SYNC    = 8'h55,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 104000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data,
  input  logic              update,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        cmd,
  output logic [7:0]        len,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              overrun
);

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  localparam logic [8:0]  MAX_LEN    = 9'(2**ADDR_W);
  localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [7:0]        chk;
  logic [ADDR_W-1:0] cnt;
  logic [19:0]       timer;
  logic              in_frame;
  logic              timeout_hit;
  logic [7:0]        payload_mem [2**ADDR_W];

  assign in_frame    = (state == ST_CMD) || (state == ST_LEN) ||
                       (state == ST_PAYLOAD) || (state == ST_CHK);
  // A strobe in the would-be timeout cycle wins: the byte is processed instead.
  assign timeout_hit = in_frame && !update && (timer == TIMER_LAST);
  assign frame_valid = (state == ST_HOLD);
  assign rd_data     = payload_mem[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HUNT;
      cmd       <= 8'h00;
      len       <= 8'h00;
      err_code  <= 2'd0;
      cnt       <= '0;
      chk       <= 8'h00;
      timer     <= 20'd0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (!in_frame || update)
        timer <= 20'd0;
      else if (timer != 20'hFFFFF)
        timer <= timer + 20'd1;

      if (timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= ST_HUNT;
      end else if (update) begin
        case (state)
          ST_HUNT: begin
            if (data == SYNC)
              state <= ST_CMD;
          end
          ST_CMD: begin
            cmd   <= data;
            chk   <= data;
            state <= ST_LEN;
          end
          ST_LEN: begin
            if ({1'b0, data} > MAX_LEN) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= ST_HUNT;
            end else begin
              len   <= data;
              chk   <= chk ^ data;
              cnt   <= '0;
              state <= (data == 8'h00) ? ST_CHK : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            chk <= chk ^ data;
            cnt <= cnt + 1'b1;
            if (8'(cnt) == len - 8'd1)
              state <= ST_CHK;
          end
          ST_CHK: begin
            if (data == chk) begin
              state <= ST_HOLD;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              state     <= ST_HUNT;
            end
          end
          ST_HOLD: overrun <= 1'b1;
          default: state <= ST_HUNT;
        endcase
      end

      if (state == ST_HOLD && frame_ack)
        state <= ST_HUNT;
    end
  end

  // Payload buffer has no reset; it is only meaningful while a frame is held.
  always_ff @(posedge clk) begin
    if (update && state == ST_PAYLOAD)
      payload_mem[cnt] <= data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus randomized
// frames checked against a frame-level model of the expected outcome.
module tb_uart_frame_parser;

  localparam int TB_TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       update;
  logic       frame_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] cmd;
  logic [7:0] len;
  logic       frame_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;

  logic [7:0] pl [16];

  uart_frame_parser #(.SYNC(8'h55), .ADDR_W(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .data(data), .update(update),
    .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd(cmd), .len(len), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Count every cycle either pulse is high, so stretched pulses show up as extra counts.
  always @(posedge clk) begin
    #2;
    if (frame_err) err_pulses++;
    if (overrun) ovr_pulses++;
  end

  function automatic logic [7:0] frame_chk(input logic [7:0] c, input logic [7:0] l);
    logic [7:0] x;
    x = c ^ l;
    for (int i = 0; i < int'(l); i++) x ^= pl[i];
    return x;
  endfunction

  // Called at a negedge; the byte is consumed by the next posedge.
  task automatic send_byte(input logic [7:0] b);
    data = b;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] l,
                            input logic [7:0] k, input int gap_max);
    send_byte(8'h55);
    idle($urandom_range(0, gap_max));
    send_byte(c);
    idle($urandom_range(0, gap_max));
    send_byte(l);
    if (l > 8'd16) return;
    for (int i = 0; i < int'(l); i++) begin
      idle($urandom_range(0, gap_max));
      send_byte(pl[i]);
    end
    idle($urandom_range(0, gap_max));
    send_byte(k);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: valid=%b err=%b ovr=%b required 000", frame_valid, frame_err, overrun);
    end
    checks++;
    if (cmd !== 8'h00 || len !== 8'h00 || err_code !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs: cmd=%h len=%h code=%0d required 00 00 0", cmd, len, err_code);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    int e0;
    e0 = err_pulses;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL good_early_valid: valid=%b required 0", frame_valid);
    end
    send_byte(8'hC3);
    checks++;
    if (frame_valid !== 1'b1 || cmd !== 8'h10 || len !== 8'h03) begin
      errors++;
      $display("[TB] FAIL good_frame: valid=%b cmd=%h len=%h required 1 10 03", frame_valid, cmd, len);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== pl[i]) begin
        errors++;
        $display("[TB] FAIL good_payload[%0d]: got %h required %h", i, rd_data, pl[i]);
      end
    end
    @(negedge clk);
    pulse_ack();
    checks++;
    if (frame_valid !== 1'b0 || err_pulses !== e0) begin
      errors++;
      $display("[TB] FAIL good_ack: valid=%b errs=%0d required 0 %0d", frame_valid, err_pulses, e0);
    end
  endtask

  task automatic test_zero_len();
    int e0;
    send_byte(8'h55); send_byte(8'h22); send_byte(8'h00); send_byte(8'h22);
    checks++;
    if (frame_valid !== 1'b1 || len !== 8'h00 || cmd !== 8'h22) begin
      errors++;
      $display("[TB] FAIL zero_len_good: valid=%b len=%h cmd=%h required 1 00 22", frame_valid, len, cmd);
    end
    pulse_ack();
    e0 = err_pulses;
    send_byte(8'h55); send_byte(8'h22); send_byte(8'h00); send_byte(8'h23);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_len_badchk: err=%b code=%0d valid=%b required 1 2 0", frame_err, err_code, frame_valid);
    end
    idle(2);
    checks++;
    if (err_pulses !== e0 + 1 || frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_len_pulses: got %0d required %0d", err_pulses - e0, 1);
    end
  endtask

  task automatic test_bad_len_noise();
    int e0;
    logic [7:0] k;
    e0 = err_pulses;
    send_byte(8'h00); send_byte(8'hFF);
    idle(2);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("[TB] FAIL noise_no_err: pulses=%0d required 0", err_pulses - e0);
    end
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h11);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      errors++;
      $display("[TB] FAIL bad_len: err=%b code=%0d required 1 1", frame_err, err_code);
    end
    idle(2);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("[TB] FAIL bad_len_pulses: got %0d required 1", err_pulses - e0);
    end
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    k = frame_chk(8'h3C, 8'd16);
    send_frame(8'h3C, 8'd16, k, 0);
    checks++;
    if (frame_valid !== 1'b1 || len !== 8'd16 || cmd !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL max_len: valid=%b len=%h cmd=%h required 1 10 3c", frame_valid, len, cmd);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== pl[i]) begin
        errors++;
        $display("[TB] FAIL max_len_payload[%0d]: got %h required %h", i, rd_data, pl[i]);
      end
    end
    @(negedge clk);
    pulse_ack();
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA);
    idle(TB_TIMEOUT - 1);
    checks++;
    if (frame_err !== 1'b0 || err_pulses !== e0) begin
      errors++;
      $display("[TB] FAIL timeout_early: err=%b pulses=%0d required 0 0", frame_err, err_pulses - e0);
    end
    idle(1);
    checks++;
    if (frame_err !== 1'b1 || err_code !== 2'd3) begin
      errors++;
      $display("[TB] FAIL timeout: err=%b code=%0d required 1 3", frame_err, err_code);
    end
    idle(TB_TIMEOUT + 5);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("[TB] FAIL timeout_single: got %0d required 1", err_pulses - e0);
    end
    e0 = err_pulses;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA);
    idle(TB_TIMEOUT - 1);
    send_byte(8'hBB);
    send_byte(8'h01 ^ 8'h02 ^ 8'hAA ^ 8'hBB);
    checks++;
    if (frame_valid !== 1'b1 || err_pulses !== e0 || cmd !== 8'h01) begin
      errors++;
      $display("[TB] FAIL timeout_edge_byte: valid=%b pulses=%0d cmd=%h required 1 0 01", frame_valid, err_pulses - e0, cmd);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    int o0;
    pl[0] = 8'h5A; pl[1] = 8'h0F;
    send_frame(8'h77, 8'd2, frame_chk(8'h77, 8'd2), 1);
    o0 = ovr_pulses;
    send_byte(8'h55);
    checks++;
    if (overrun !== 1'b1 || frame_valid !== 1'b1 || cmd !== 8'h77 || len !== 8'd2) begin
      errors++;
      $display("[TB] FAIL overrun_first: ovr=%b valid=%b cmd=%h len=%h required 1 1 77 02", overrun, frame_valid, cmd, len);
    end
    for (int i = 0; i < 2; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== pl[i]) begin
        errors++;
        $display("[TB] FAIL overrun_payload[%0d]: got %h required %h", i, rd_data, pl[i]);
      end
    end
    @(negedge clk);
    data = 8'h99;
    update = 1'b1;
    frame_ack = 1'b1;
    @(negedge clk);
    update = 1'b0;
    frame_ack = 1'b0;
    checks++;
    if (overrun !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_with_ack: ovr=%b valid=%b required 1 0", overrun, frame_valid);
    end
    idle(2);
    checks++;
    if (ovr_pulses !== o0 + 2) begin
      errors++;
      $display("[TB] FAIL overrun_count: got %0d required 2", ovr_pulses - o0);
    end
    pl[0] = 8'h44;
    send_frame(8'h12, 8'd1, frame_chk(8'h12, 8'd1), 0);
    checks++;
    if (frame_valid !== 1'b1 || cmd !== 8'h12) begin
      errors++;
      $display("[TB] FAIL after_overrun: valid=%b cmd=%h required 1 12", frame_valid, cmd);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h55); send_byte(8'h5A); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cmd !== 8'h00 || len !== 8'h00 || err_code !== 2'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: cmd=%h len=%h code=%0d valid=%b err=%b required 00 00 0 0 0", cmd, len, err_code, frame_valid, frame_err);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pl[0] = 8'hDE; pl[1] = 8'hAD;
    send_frame(8'h5A, 8'd2, frame_chk(8'h5A, 8'd2), 0);
    checks++;
    if (frame_valid !== 1'b1 || cmd !== 8'h5A || len !== 8'd2) begin
      errors++;
      $display("[TB] FAIL reset_mid_recover: valid=%b cmd=%h len=%h required 1 5a 02", frame_valid, cmd, len);
    end
    pulse_ack();
  endtask

  task automatic test_random();
    int kind, e0, nnoise;
    logic [7:0] c, l, k, b;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      nnoise = $urandom_range(0, 2);
      for (int j = 0; j < nnoise; j++) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h56;
        send_byte(b);
        idle($urandom_range(0, 2));
      end
      c = 8'($urandom);
      l = (kind == 1) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(0, 16));
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      k = frame_chk(c, l);
      if (kind == 2) k = k ^ 8'($urandom_range(1, 255));
      e0 = err_pulses;
      send_frame(c, l, k, 3);
      if (kind == 0) begin
        checks++;
        if (frame_valid !== 1'b1 || cmd !== c || len !== l) begin
          errors++;
          $display("[TB] FAIL rand_good[%0d]: valid=%b cmd=%h len=%h required 1 %h %h", n, frame_valid, cmd, len, c, l);
        end
        for (int i = 0; i < int'(l); i++) begin
          rd_addr = 4'(i);
          #1;
          checks++;
          if (rd_data !== pl[i]) begin
            errors++;
            $display("[TB] FAIL rand_payload[%0d][%0d]: got %h required %h", n, i, rd_data, pl[i]);
          end
        end
        @(negedge clk);
        idle($urandom_range(0, 3));
        pulse_ack();
        checks++;
        if (frame_valid !== 1'b0 || err_pulses !== e0) begin
          errors++;
          $display("[TB] FAIL rand_ack[%0d]: valid=%b errs=%0d required 0 0", n, frame_valid, err_pulses - e0);
        end
      end else begin
        idle(2);
        checks++;
        if (err_pulses !== e0 + 1 || err_code !== 2'(kind) || frame_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand_err[%0d]: pulses=%0d code=%0d valid=%b required 1 %0d 0", n, err_pulses - e0, err_code, frame_valid, kind);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    data = 8'h00;
    update = 1'b0;
    frame_ack = 1'b0;
    rd_addr = 4'd0;
    test_reset();
    test_good_frame();
    test_zero_len();
    test_bad_len_noise();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
